// File: rtl/debug_text_pkg.sv
// Shared definitions for the debug text overlay blocks: FSM states, ASCII anchors, line length.
// Build option: DEBUG_HEX_SEPARATOR_EN adds the group-separator state and lengthens each line.
package debug_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_EOL   = 2'd3
`ifdef DEBUG_HEX_SEPARATOR_EN
        ,
        ST_SEP   = 2'd2
`endif
    } state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

`ifdef DEBUG_HEX_SEPARATOR_EN
    localparam int DEBUG_LINE_CHARS = 20;
`else
    localparam int DEBUG_LINE_CHARS = 17;
`endif

endpackage

// File: rtl/debug_hex_digit.sv
// Combinational nibble to uppercase ASCII hex encoder, shared by the overlay text blocks.
module debug_hex_digit
    import debug_text_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] char_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            char_o = ASCII_ZERO + {4'h0, nib_i};
        end else begin
            char_o = ASCII_UPPER_A + {4'h0, nib_i - 4'd10};
        end
    end

endmodule

// File: rtl/debug_hex_streamer.sv
// Snapshots NUM_LINES 64-bit debug words on inFrameStart and streams them as ASCII hex lines.
// Build option: define DEBUG_HEX_SEPARATOR_EN to insert CHAR_SEPARATOR between 4-digit groups.
module debug_hex_streamer
    import debug_text_pkg::*;
#(
    parameter int         NUM_LINES      = 5,
    parameter logic [7:0] CHAR_NEWLINE   = 8'h0A,
    parameter logic [7:0] CHAR_SEPARATOR = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inFrameStart,
    input  logic [63:0] inDebug [NUM_LINES-1:0],
    output logic        outCharValid,
    output logic [7:0]  outChar,
    input  logic        inCharReady,
    output logic        outLineEnd,
    output logic        outBusy,
    output logic [7:0]  outDroppedFrames
);

    localparam logic [2:0] LAST_LINE = 3'(NUM_LINES - 1);

    if (NUM_LINES < 1 || NUM_LINES > 8) begin : g_bad_num_lines
        $error("debug_hex_streamer: NUM_LINES must be 1..8");
    end
    if (CHAR_SEPARATOR == CHAR_NEWLINE) begin : g_bad_separator
        $error("debug_hex_streamer: separator must differ from newline");
    end

    state_e      state_q, state_d;
    logic [2:0]  line_q, line_d;
    logic [3:0]  digit_q, digit_d;
    logic [63:0] snap_q [NUM_LINES-1:0];
    logic        valid_q, eol_q, busy_q;
    logic [7:0]  char_q, char_d;
    logic [7:0]  drop_q;

    logic        capture;
    logic        xfer;
    logic [63:0] word_sel;
    logic [3:0]  nib_sel;
    logic [7:0]  nib_char;

    assign xfer    = valid_q & inCharReady;
    assign capture = (state_q == ST_IDLE) && inFrameStart;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        digit_d = digit_q;
        case (state_q)
            ST_IDLE: begin
                if (inFrameStart) begin
                    line_d  = 3'd0;
                    digit_d = 4'd15;
                    state_d = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (xfer) begin
                    if (digit_q == 4'd0) begin
                        state_d = ST_EOL;
                    end else begin
                        digit_d = digit_q - 4'd1;
`ifdef DEBUG_HEX_SEPARATOR_EN
                        if (digit_q == 4'd12 || digit_q == 4'd8 || digit_q == 4'd4) begin
                            state_d = ST_SEP;
                        end
`endif
                    end
                end
            end
`ifdef DEBUG_HEX_SEPARATOR_EN
            ST_SEP: begin
                if (xfer) begin
                    state_d = ST_DIGIT;
                end
            end
`endif
            ST_EOL: begin
                if (xfer) begin
                    if (line_q == LAST_LINE) begin
                        state_d = ST_IDLE;
                    end else begin
                        line_d  = line_q + 3'd1;
                        digit_d = 4'd15;
                        state_d = ST_DIGIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The character register is loaded from the next state, so on the capture cycle the
    // first digit has to come straight from inDebug rather than the not-yet-written snapshot.
    always_comb begin
        word_sel = snap_q[0];
        for (int i = 0; i < NUM_LINES; i++) begin
            if (line_d == 3'(i)) begin
                word_sel = snap_q[i];
            end
        end
        if (capture) begin
            word_sel = inDebug[0];
        end
        nib_sel = word_sel[{digit_d, 2'b00} +: 4];
    end

    debug_hex_digit u_hex_digit (
        .nib_i  (nib_sel),
        .char_o (nib_char)
    );

    always_comb begin
        char_d = 8'h00;
        case (state_d)
            ST_DIGIT: char_d = nib_char;
`ifdef DEBUG_HEX_SEPARATOR_EN
            ST_SEP:   char_d = CHAR_SEPARATOR;
`endif
            ST_EOL:   char_d = CHAR_NEWLINE;
            default:  char_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= 3'd0;
            digit_q <= 4'd0;
            valid_q <= 1'b0;
            char_q  <= 8'h00;
            eol_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            digit_q <= digit_d;
            valid_q <= (state_d != ST_IDLE);
            char_q  <= char_d;
            eol_q   <= (state_d == ST_EOL);
            busy_q  <= (state_d != ST_IDLE);
            if (inFrameStart && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            snap_q <= inDebug;
        end
    end

    assign outCharValid     = valid_q;
    assign outChar          = char_q;
    assign outLineEnd       = eol_q;
    assign outBusy          = busy_q;
    assign outDroppedFrames = drop_q;

endmodule

// File: tb/tb_debug_hex_streamer.sv
// Randomized self-checking bench for debug_hex_streamer against a string-level reference model.
module tb_debug_hex_streamer;
    import debug_text_pkg::*;

    localparam int         NL    = 5;
    localparam logic [7:0] NLCH  = 8'h0A;
    localparam logic [7:0] SEPCH = 8'h20;

    logic        clock = 1'b0;
    logic        reset;
    logic        inFrameStart;
    logic        inCharReady;
    logic [63:0] inDebug [NL-1:0];
    logic        outCharValid;
    logic [7:0]  outChar;
    logic        outLineEnd;
    logic        outBusy;
    logic [7:0]  outDroppedFrames;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] words [NL];
    logic [7:0]  exp_q [$];
    int          drop_exp = 0;
    int          pulses = 0;
    int          lineend_cnt = 0;
    int          busy_cycles = 0;
    string       hexdig = "0123456789ABCDEF";

    always #5 clock = ~clock;

    debug_hex_streamer #(
        .NUM_LINES      (NL),
        .CHAR_NEWLINE   (NLCH),
        .CHAR_SEPARATOR (SEPCH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .inFrameStart     (inFrameStart),
        .inDebug          (inDebug),
        .outCharValid     (outCharValid),
        .outChar          (outChar),
        .inCharReady      (inCharReady),
        .outLineEnd       (outLineEnd),
        .outBusy          (outBusy),
        .outDroppedFrames (outDroppedFrames)
    );

    // Reference: print each word as 16 uppercase hex digits, optional spaces every 4, newline.
    task automatic build_expected();
        logic [63:0] w;
        int n;
        exp_q.delete();
        for (int l = 0; l < NL; l++) begin
            w = words[l];
            for (int d = 15; d >= 0; d--) begin
                n = int'((w >> (d * 4)) & 64'hF);
                exp_q.push_back(hexdig[n]);
`ifdef DEBUG_HEX_SEPARATOR_EN
                if (d == 12 || d == 8 || d == 4) exp_q.push_back(SEPCH);
`endif
            end
            exp_q.push_back(NLCH);
        end
    endtask

    task automatic run_stream(input int rdy_pct, input bit mutate, input bit drops);
        logic [7:0] held;
        logic [7:0] e;
        bit         was_stall;
        int         cyc;
        for (int i = 0; i < NL; i++) inDebug[i] = words[i];
        build_expected();
        lineend_cnt  = 0;
        busy_cycles  = 0;
        was_stall    = 0;
        cyc          = 0;
        held         = 8'h00;
        inCharReady  = 1'b0;
        inFrameStart = 1'b1;
        @(posedge clock); #1;
        inFrameStart = 1'b0;
        vectors++;
        if (outCharValid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_valid: got %b want 1", outCharValid);
        end
        while (exp_q.size() > 0 && cyc < 4000) begin
            cyc++;
            if (outBusy === 1'b1) busy_cycles++;
            inCharReady = ($urandom_range(0, 99) < rdy_pct);
            if (drops) begin
                inFrameStart = ($urandom_range(0, 1) == 1) || (exp_q.size() == 1 && inCharReady);
                if (inFrameStart) begin
                    pulses++;
                    if (drop_exp < 255) drop_exp++;
                end
            end
            if (mutate) begin
                for (int i = 0; i < NL; i++) inDebug[i] = {$urandom, $urandom};
            end
            vectors++;
            if (outCharValid !== 1'b1) begin
                miscompares++;
                $display("FAIL valid_mid_stream: got %b want 1 (%0d chars left)", outCharValid, exp_q.size());
            end
            if (was_stall) begin
                vectors++;
                if (outChar !== held) begin
                    miscompares++;
                    $display("FAIL stall_stable: got %h want %h", outChar, held);
                end
            end
            if (inCharReady) begin
                e = exp_q.pop_front();
                vectors++;
                if (outChar !== e) begin
                    miscompares++;
                    $display("FAIL char: got %h want %h (%0d left)", outChar, e, exp_q.size());
                end
                vectors++;
                if (outLineEnd !== (e == NLCH)) begin
                    miscompares++;
                    $display("FAIL line_end: got %b want %b", outLineEnd, (e == NLCH));
                end
                if (outLineEnd === 1'b1) lineend_cnt++;
                was_stall = 0;
            end else begin
                held      = outChar;
                was_stall = 1;
            end
            @(posedge clock); #1;
            inFrameStart = 1'b0;
        end
        inCharReady = 1'b0;
        vectors++;
        if (cyc >= 4000) begin
            miscompares++;
            $display("FAIL stream_timeout: %0d chars never transferred, want 0", exp_q.size());
        end
        vectors++;
        if (outCharValid !== 1'b0 || outBusy !== 1'b0 || outLineEnd !== 1'b0) begin
            miscompares++;
            $display("FAIL end_idle: valid/busy/eol got %b%b%b want 000", outCharValid, outBusy, outLineEnd);
        end
        vectors++;
        if (outDroppedFrames !== 8'(drop_exp)) begin
            miscompares++;
            $display("FAIL dropped: got %0d want %0d", outDroppedFrames, drop_exp);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        inFrameStart = 1'b0;
        inCharReady  = 1'b0;
        for (int i = 0; i < NL; i++) inDebug[i] = 64'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        vectors++;
        if (outCharValid !== 1'b0 || outChar !== 8'h00 || outLineEnd !== 1'b0 ||
            outBusy !== 1'b0 || outDroppedFrames !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b char=%h eol=%b busy=%b drop=%0d want 0/00/0/0/0",
                     outCharValid, outChar, outLineEnd, outBusy, outDroppedFrames);
        end
    endtask

    task automatic test_uppercase();
        words[0] = 64'h0123456789ABCDEF;
        words[1] = 64'hFEDCBA9876543210;
        words[2] = 64'h0;
        words[3] = 64'hFFFFFFFFFFFFFFFF;
        words[4] = {$urandom, $urandom};
        run_stream(100, 0, 0);
        vectors++;
        if (busy_cycles != NL * DEBUG_LINE_CHARS) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d want %0d", busy_cycles, NL * DEBUG_LINE_CHARS);
        end
    endtask

    task automatic test_multiline();
        for (int i = 0; i < NL; i++) words[i] = 64'(i + 1);
        run_stream(100, 0, 0);
        vectors++;
        if (lineend_cnt != NL) begin
            miscompares++;
            $display("FAIL line_count: got %0d want %0d", lineend_cnt, NL);
        end
    endtask

    task automatic test_backpressure();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NL; i++) words[i] = {$urandom, $urandom};
            run_stream(50, 1, 0);
        end
    endtask

    task automatic test_dropped();
        while (pulses < 300) begin
            for (int i = 0; i < NL; i++) words[i] = {$urandom, $urandom};
            run_stream(80, 0, 1);
        end
        vectors++;
        if (outDroppedFrames !== 8'd255) begin
            miscompares++;
            $display("FAIL drop_saturate: got %0d want 255", outDroppedFrames);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] e;
        for (int i = 0; i < NL; i++) words[i] = {$urandom, $urandom};
        for (int i = 0; i < NL; i++) inDebug[i] = words[i];
        build_expected();
        inFrameStart = 1'b1;
        inCharReady  = 1'b1;
        @(posedge clock); #1;
        inFrameStart = 1'b0;
        for (int k = 0; k < 7; k++) begin
            e = exp_q.pop_front();
            vectors++;
            if (outChar !== e || outCharValid !== 1'b1) begin
                miscompares++;
                $display("FAIL pre_reset_char: got %b/%h want 1/%h", outCharValid, outChar, e);
            end
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset    = 1'b0;
        drop_exp = 0;
        vectors++;
        if (outCharValid !== 1'b0 || outBusy !== 1'b0 || outDroppedFrames !== 8'h00 ||
            outChar !== 8'h00 || outLineEnd !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b busy=%b drop=%0d char=%h eol=%b want 0/0/0/00/0",
                     outCharValid, outBusy, outDroppedFrames, outChar, outLineEnd);
        end
        @(posedge clock); #1;
        vectors++;
        if (outCharValid !== 1'b0 || outBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: valid=%b busy=%b want 0/0", outCharValid, outBusy);
        end
        for (int i = 0; i < NL; i++) words[i] = {$urandom, $urandom};
        run_stream(100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_uppercase();
        test_multiline();
        test_backpressure();
        test_dropped();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debug_hex_streamer.md
# debug_hex_streamer

Converts the multiplexed 64-bit debug words into a stream of ASCII hex characters for the on-screen text overlay. It sits downstream of the debug selection logic and upstream of the overlay character writer. On each frame-start pulse it snapshots all words and emits them MSB-nibble first, one line per word. Output uses a valid/ready handshake.

## Interface
Parameters:
- NUM_LINES, 5: number of 64-bit debug words streamed per frame (1..8).
- CHAR_NEWLINE, 8'h0A: character code emitted at the end of each line.
- CHAR_SEPARATOR, 8'h20: group separator character; used only when DEBUG_HEX_SEPARATOR_EN is defined.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- inFrameStart  in  1  single-cycle pulse requesting a new snapshot and stream.
- inDebug[NUM_LINES-1:0]  in  64 each  debug words; index 0 streams first.
- outCharValid  out  1  outChar holds a character.
- outChar  out  8  ASCII character.
- inCharReady  in  1  consumer accepts the character this cycle.
- outLineEnd  out  1  high while outChar is CHAR_NEWLINE.
- outBusy  out  1  stream in progress (state != IDLE).
- outDroppedFrames  out  8  saturating count of ignored inFrameStart pulses.

## Operation
- States: IDLE, DIGIT, SEP (macro only), EOL.
- IDLE: when inFrameStart=1, capture all inDebug words into a snapshot register, set lineIdx=0 and digitIdx=15, and go to DIGIT. Otherwise remain in IDLE.
- DIGIT: outChar is the ASCII code of snapshot[lineIdx][digitIdx*4+3 -: 4].
  - Nibbles 0-9 map to 8'h30-8'h39.
  - Nibbles A-F map to 8'h41-8'h46 (uppercase).
- Handshake: a character transfers only when outCharValid & inCharReady. Each state advances only on a transfer.
- DIGIT on transfer:
  - If digitIdx==0, go to EOL.
  - Else if the macro is on and digitIdx is 12, 8 or 4, decrement digitIdx and go to SEP.
  - Otherwise decrement digitIdx and stay in DIGIT.
- SEP: outChar=CHAR_SEPARATOR; on transfer, go to DIGIT.
- EOL: outChar=CHAR_NEWLINE and outLineEnd=1. On transfer:
  - If lineIdx==NUM_LINES-1, go to IDLE.
  - Otherwise increment lineIdx, set digitIdx=15 and go to DIGIT.
- Snapshot: held constant for the whole stream; changes on inDebug mid-stream are not visible.
- Valid/char stability: once outCharValid is high, outChar and outCharValid stay stable until the transfer.
- inFrameStart while not IDLE is ignored and increments outDroppedFrames, which saturates at 255. This includes the cycle of the final EOL transfer.
- outDroppedFrames clears only on reset.
- Widths: lineIdx is 3 bits; digitIdx is 4 bits.

## Timing
- Reset values: outCharValid=0, outChar=8'h00, outLineEnd=0, outBusy=0, outDroppedFrames=0, state IDLE.
- All outputs are registered.
- First character: outCharValid rises on the edge after the cycle in which inFrameStart is sampled.
- Throughput: one character per cycle while inCharReady is held high.
- Stream length: NUM_LINES*17 characters without the macro, NUM_LINES*20 with it.
- With inCharReady=1 throughout, outBusy is high for exactly that many cycles.
- outBusy and outCharValid fall on the edge following the final EOL transfer.
- Reset mid-stream: on the next edge all outputs return to reset values and the snapshot is discarded. No partial resume.

## Configuration
- DEBUG_HEX_SEPARATOR_EN defined:
  - SEP state exists.
  - CHAR_SEPARATOR is emitted after digits 15..12, 11..8 and 7..4.
  - Line format is "XXXX XXXX XXXX XXXX\n" (20 characters).
- Not defined:
  - SEP state and its logic are absent.
  - Line format is 16 contiguous hex digits plus newline (17 characters).
  - CHAR_SEPARATOR is unused.

## Structure
- Shared package debug_text_pkg holds:
  - state enum type;
  - ASCII constants for '0' and 'A';
  - DEBUG_LINE_CHARS constant (17 or 20, selected by the macro).
- One natural sub-module: debug_hex_digit, a combinational 4-bit nibble to 8-bit ASCII encoder. It is also reusable by other overlay blocks.
- The top module holds the snapshot registers, the FSM, the counters and the drop counter.

## Test plan
- Uppercase hex: inDebug[0]=64'h0123456789ABCDEF, NUM_LINES=1, ready held high, no macro -> "0123456789ABCDEF\n" on consecutive cycles. Valid rises 1 cycle after inFrameStart.
- Separator: macro defined, inDebug[0]=64'hDEADBEEFCAFEF00D -> "DEAD BEEF CAFE F00D\n"; outBusy high for 20 cycles.
- Backpressure and snapshot: inCharReady toggled pseudo-randomly, inDebug changed mid-stream -> outChar/outCharValid stable while not ready, and the full original snapshot is streamed with no loss or duplication.
- Multi-line: NUM_LINES=5 with words 64'h1..64'h5 -> 5 lines, outLineEnd high exactly 5 times, final line "0000000000000005\n", then IDLE.
- Dropped frames: 300 inFrameStart pulses during streams, including one coincident with the final EOL transfer -> outDroppedFrames saturates at 255, and the current stream is unaffected.
- Reset mid-stream: reset asserted after the 7th character -> next edge gives outCharValid=0, outBusy=0, outDroppedFrames=0; a new inFrameStart restarts from line 0, digit 15.
